regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Owns the two write ports of the dual-issue regfile. Passes the in-order writebacks
//  of pipe 0 and pipe 1 straight through. Buffers results from the long-latency unit
//  (mul/div, load miss) and merges them into idle port slots.
//  Keeps a per-register busy/stale scoreboard, so issue can stall on pending LL results
//  and stale LL results are never written over younger data.
//  Sits between the WB stage / LL unit and the regfile; busy_mask feeds issue.
// PARAMETERS
//  DATA_W      32  register data width
//  ADDR_W      5   register address width (2**ADDR_W registers; r0 hard-wired zero)
//  FIFO_DEPTH  2   LL result buffer entries (power of 2, >=2)
// PORTS
//  clk         in   1       clock, all state on posedge
//  resetn      in   1       synchronous, active-low reset
//  wb0_we      in   1       pipe 0 (older) writeback enable
//  wb0_addr    in   ADDR_W  pipe 0 dest
//  wb0_data    in   DATA_W  pipe 0 data
//  wb1_we      in   1       pipe 1 (younger) writeback enable
//  wb1_addr    in   ADDR_W  pipe 1 dest
//  wb1_data    in   DATA_W  pipe 1 data
//  alloc_valid in   1       issue of an LL op this cycle
//  alloc_addr  in   ADDR_W  LL op dest
//  ll_valid    in   1       LL result offered
//  ll_ready    out  1       LL result accepted when valid&ready
//  ll_addr     in   ADDR_W  LL result dest
//  ll_data     in   DATA_W  LL result data
//  rf_we1      out  1       regfile port 1 enable
//  rf_waddr1   out  ADDR_W  port 1 address
//  rf_wdata1   out  DATA_W  port 1 data
//  rf_we2      out  1       regfile port 2 enable (wins same-address collisions)
//  rf_waddr2   out  ADDR_W  port 2 address
//  rf_wdata2   out  DATA_W  port 2 data
//  busy_mask   out  2**ADDR_W  bit n = LL result for rN outstanding (buffered or in flight)
// BEHAVIOUR
//  Reset: FIFO empty, busy=0, stale=0. While resetn=0: rf_we1=rf_we2=0 and ll_ready=0.
//  Any write/alloc/result with addr 0 is a no-op. busy[0] and stale[0] are always 0.
//  Pipe writes are combinational pass-through: wb0 -> port 1, wb1 -> port 2. Zero latency.
//  ll_ready = (count != FIFO_DEPTH), taken from registered count. No same-cycle bypass:
//    - a full FIFO keeps ready=0 even when it drains that cycle;
//    - an accepted result is written no earlier than the next cycle.
//  Drain: the FIFO head is written on port 1 if wb0_we=0, else on port 2 if wb1_we=0,
//    else it waits. At most one pop per cycle. Pop happens whenever the head is issued.
//  Stale rule: a pipe write to rN with busy[N]=1 sets stale[N]; the LL result is older.
//    The head write is suppressed (rf_we=0, entry still popped) if stale[addr] is set,
//    or if a pipe write hits the same addr in the same cycle.
//  Pop of head rN clears busy[N] and stale[N], whether the write was done or suppressed.
//  Alloc to rN sets busy[N] and clears stale[N].
//    - Alloc beats a same-cycle pipe write to rN (no stale set).
//    - Alloc beats a same-cycle pop of rN: busy stays 1.
//  Alloc to an already-busy register is illegal, because issue stalls on it. Assert it.
//  ll_valid with busy[ll_addr]=0 is illegal. Assert it.
//  wb0/wb1 with the same addr: both ports drive it, and port 2 (younger) wins in the regfile.
//  Pointers wrap mod FIFO_DEPTH. count is updated as +push -pop in the same cycle.
//  A reset mid-operation discards all buffered results and clears the scoreboard.
// STRUCTURE
//  Shared package: DATA_W/ADDR_W defaults, NUM_REGS=2**ADDR_W, ll_entry_t {addr,data}.
//  Sub-module ll_result_fifo: sync FIFO, push/pop/full/empty/head. Same clk/resetn.
//  Top level holds the busy/stale scoreboard and the port-select mux.
// TESTING
//  1 Passthrough: wb0 r3=0x11, wb1 r4=0x22 -> rf_we1/2=1 same cycle; ll_ready=1; busy=0.
//  2 LL fill: alloc r5; then ll r5=0xAA, wb0/wb1 both busy 2 cycles
//    -> held in FIFO, busy[5]=1; first cycle wb1_we=0 -> port 2 writes 0xAA, busy[5]=0.
//  3 Full: alloc r6,r7; push 2 results with both pipes writing -> ll_ready=0 for the
//    3rd offer; free port 1 -> r6 written, next cycle ready=1.
//  4 Stale: alloc r8; wb0 r8=0x1 -> stale[8]=1; ll r8=0x2 drains
//    -> rf_we=0 for it, r8 stays 0x1, busy/stale[8]=0.
//  5 Same-cycle: alloc r9 with wb1 r9 -> busy[9]=1, stale[9]=0.
//    Head r10 with wb0 r10 -> head suppressed.
//  6 Reset with 2 buffered entries -> count=0, busy=0, ll_ready=0 during reset, 1 after.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and types for the regfile writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned DefDataW     = 32;
  localparam int unsigned DefAddrW     = 5;
  localparam int unsigned DefFifoDepth = 2;
  localparam int unsigned NumRegs      = 2 ** DefAddrW;

  // One buffered long-latency result.
  typedef struct packed {
    logic [DefAddrW-1:0] addr;
    logic [DefDataW-1:0] data;
  } ll_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_ll_result_fifo.sv
// Synchronous FIFO holding long-latency results until a regfile port slot is free.
// Full/empty come from the registered count, so there is no same-cycle bypass.
module regfile_wb_arbiter_ll_result_fifo #(
  parameter int unsigned Width = 37,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];

  // Next-state for pointers, count and storage; pointers wrap naturally (Depth is 2**n).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + {{(CntW-1){1'b0}}, push} - {{(CntW-1){1'b0}}, pop};
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns both regfile write ports: pipe writebacks pass straight through, buffered
// long-latency results fill idle slots, and a busy/stale scoreboard stops stale LL
// data from overwriting younger pipe results.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 wb0_we,
  input  logic [ADDR_W-1:0]    wb0_addr,
  input  logic [DATA_W-1:0]    wb0_data,
  input  logic                 wb1_we,
  input  logic [ADDR_W-1:0]    wb1_addr,
  input  logic [DATA_W-1:0]    wb1_data,
  input  logic                 alloc_valid,
  input  logic [ADDR_W-1:0]    alloc_addr,
  input  logic                 ll_valid,
  output logic                 ll_ready,
  input  logic [ADDR_W-1:0]    ll_addr,
  input  logic [DATA_W-1:0]    ll_data,
  output logic                 rf_we1,
  output logic [ADDR_W-1:0]    rf_waddr1,
  output logic [DATA_W-1:0]    rf_wdata1,
  output logic                 rf_we2,
  output logic [ADDR_W-1:0]    rf_waddr2,
  output logic [DATA_W-1:0]    rf_wdata2,
  output logic [2**ADDR_W-1:0] busy_mask
);

  localparam int unsigned NRegs  = 2 ** ADDR_W;
  localparam int unsigned EntryW = ADDR_W + DATA_W;

  logic [NRegs-1:0]  busy_q, busy_d;
  logic [NRegs-1:0]  stale_q, stale_d;

  logic              wb0_act, wb1_act, alloc_act, push;
  logic              fifo_full, fifo_empty;
  logic [EntryW-1:0] fifo_head;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              head_to_p1, head_to_p2, pop, head_kill;

  // r0 is hard-wired zero, so anything aimed at it does nothing.
  assign wb0_act   = wb0_we && (wb0_addr != '0);
  assign wb1_act   = wb1_we && (wb1_addr != '0);
  assign alloc_act = alloc_valid && (alloc_addr != '0);

  assign ll_ready = resetn && !fifo_full;
  assign push     = ll_valid && ll_ready && (ll_addr != '0);

  regfile_wb_arbiter_ll_result_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_ll_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .wdata  ({ll_addr, ll_data}),
    .pop    (pop),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign head_addr = fifo_head[EntryW-1 -: ADDR_W];
  assign head_data = fifo_head[DATA_W-1:0];

  // Slot selection for the FIFO head and the two regfile port muxes.
  always_comb begin
    head_to_p1 = 1'b0;
    head_to_p2 = 1'b0;
    if (resetn && !fifo_empty) begin
      if (!wb0_we) begin
        head_to_p1 = 1'b1;
      end else if (!wb1_we) begin
        head_to_p2 = 1'b1;
      end
    end
    pop = head_to_p1 || head_to_p2;

    // A younger pipe result (earlier or this cycle) makes the LL data obsolete.
    head_kill = stale_q[head_addr] ||
                (wb0_act && (wb0_addr == head_addr)) ||
                (wb1_act && (wb1_addr == head_addr)) ||
                (head_addr == '0);

    rf_we1    = resetn && (wb0_act || (head_to_p1 && !head_kill));
    rf_waddr1 = head_to_p1 ? head_addr : wb0_addr;
    rf_wdata1 = head_to_p1 ? head_data : wb0_data;
    rf_we2    = resetn && (wb1_act || (head_to_p2 && !head_kill));
    rf_waddr2 = head_to_p2 ? head_addr : wb1_addr;
    rf_wdata2 = head_to_p2 ? head_data : wb1_data;
  end

  // Scoreboard update; later statements take priority (pipe < pop < alloc).
  always_comb begin
    busy_d  = busy_q;
    stale_d = stale_q;
    if (wb0_act && busy_q[wb0_addr]) stale_d[wb0_addr] = 1'b1;
    if (wb1_act && busy_q[wb1_addr]) stale_d[wb1_addr] = 1'b1;
    if (pop) begin
      busy_d[head_addr]  = 1'b0;
      stale_d[head_addr] = 1'b0;
    end
    if (alloc_act) begin
      busy_d[alloc_addr]  = 1'b1;
      stale_d[alloc_addr] = 1'b0;
    end
    busy_d[0]  = 1'b0;
    stale_d[0] = 1'b0;
  end

  // Scoreboard registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_q  <= '0;
      stale_q <= '0;
    end else begin
      busy_q  <= busy_d;
      stale_q <= stale_d;
    end
  end

  assign busy_mask = busy_q;

  // Issue stalls on busy registers, so a second alloc can only coincide with the pop.
  a_alloc_not_busy : assert property (@(posedge clk) disable iff (!resetn)
    alloc_act |-> (!busy_q[alloc_addr] || (pop && (head_addr == alloc_addr))));

  // Every LL result must have been allocated beforehand.
  a_ll_was_alloc : assert property (@(posedge clk) disable iff (!resetn)
    (ll_valid && (ll_addr != '0)) |-> busy_q[ll_addr]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: expected regfile writes are queued as stimulus is driven and
// compared against every rf_we pulse seen at the falling clock edge.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  typedef struct packed {
    logic [1:0] port;
    ll_entry_t  e;
  } exp_t;

  logic                clk;
  logic                resetn;
  logic                wb0_we, wb1_we, alloc_valid, ll_valid, ll_ready;
  logic [DefAddrW-1:0] wb0_addr, wb1_addr, alloc_addr, ll_addr;
  logic [DefDataW-1:0] wb0_data, wb1_data, ll_data;
  logic                rf_we1, rf_we2;
  logic [DefAddrW-1:0] rf_waddr1, rf_waddr2;
  logic [DefDataW-1:0] rf_wdata1, rf_wdata2;
  logic [NumRegs-1:0]  busy_mask;

  int   tests_run = 0;
  int   fails     = 0;
  exp_t exp_q[$];
  logic [DefDataW-1:0] rf_model [NumRegs];

  regfile_wb_arbiter dut (
    .clk         (clk),
    .resetn      (resetn),
    .wb0_we      (wb0_we),
    .wb0_addr    (wb0_addr),
    .wb0_data    (wb0_data),
    .wb1_we      (wb1_we),
    .wb1_addr    (wb1_addr),
    .wb1_data    (wb1_data),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .ll_valid    (ll_valid),
    .ll_ready    (ll_ready),
    .ll_addr     (ll_addr),
    .ll_data     (ll_data),
    .rf_we1      (rf_we1),
    .rf_waddr1   (rf_waddr1),
    .rf_wdata1   (rf_wdata1),
    .rf_we2      (rf_we2),
    .rf_waddr2   (rf_waddr2),
    .rf_wdata2   (rf_wdata2),
    .busy_mask   (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every regfile write must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rf_we1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL port1_write: unexpected write r%0d=%h, none expected", rf_waddr1, rf_wdata1);
      end else begin
        e = exp_q.pop_front();
        if (e.port !== 2'd1 || e.e.addr !== rf_waddr1 || e.e.data !== rf_wdata1) begin
          fails++;
          $display("FAIL port1_write: got port1 r%0d=%h, expected port%0d r%0d=%h",
                   rf_waddr1, rf_wdata1, e.port, e.e.addr, e.e.data);
        end
      end
      rf_model[rf_waddr1] = rf_wdata1;
    end
    if (rf_we2) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL port2_write: unexpected write r%0d=%h, none expected", rf_waddr2, rf_wdata2);
      end else begin
        e = exp_q.pop_front();
        if (e.port !== 2'd2 || e.e.addr !== rf_waddr2 || e.e.data !== rf_wdata2) begin
          fails++;
          $display("FAIL port2_write: got port2 r%0d=%h, expected port%0d r%0d=%h",
                   rf_waddr2, rf_wdata2, e.port, e.e.addr, e.e.data);
        end
      end
      rf_model[rf_waddr2] = rf_wdata2;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb0_we = 0; wb0_addr = '0; wb0_data = '0;
    wb1_we = 0; wb1_addr = '0; wb1_data = '0;
    alloc_valid = 0; alloc_addr = '0;
    ll_valid = 0; ll_addr = '0; ll_data = '0;
  endtask

  task automatic pipe0(input logic [4:0] a, input logic [31:0] d);
    wb0_we = 1; wb0_addr = a; wb0_data = d;
    exp_q.push_back({2'd1, a, d});
  endtask

  task automatic pipe1(input logic [4:0] a, input logic [31:0] d);
    wb1_we = 1; wb1_addr = a; wb1_data = d;
    exp_q.push_back({2'd2, a, d});
  endtask

  task automatic check_drained(input string name);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_pending: %0d expected writes never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    resetn = 0;
    idle();
    wb0_we = 1; wb0_addr = 5'd3; wb0_data = 32'hDEAD;
    #1;
    tests_run++;
    if (rf_we1 !== 1'b0 || rf_we2 !== 1'b0 || ll_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_gating: we1=%b we2=%b ready=%b, required 0 0 0", rf_we1, rf_we2, ll_ready);
    end
    tick(); tick();
    tests_run++;
    if (busy_mask !== '0) begin
      fails++;
      $display("FAIL reset_busy: busy=%h, required 0", busy_mask);
    end
    resetn = 1;
    idle();
    tick();
    tests_run++;
    if (ll_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: ready=%b, required 1", ll_ready);
    end
    check_drained("reset");
  endtask

  task automatic test_passthrough();
    pipe0(5'd3, 32'h11);
    pipe1(5'd4, 32'h22);
    #1;
    tests_run++;
    if (rf_we1 !== 1 || rf_waddr1 !== 5'd3 || rf_we2 !== 1 || rf_waddr2 !== 5'd4 ||
        ll_ready !== 1 || busy_mask !== '0) begin
      fails++;
      $display("FAIL passthrough: we1=%b a1=%0d we2=%b a2=%0d ready=%b busy=%h, required 1 3 1 4 1 0",
               rf_we1, rf_waddr1, rf_we2, rf_waddr2, ll_ready, busy_mask);
    end
    tick();
    idle();
    tests_run++;
    if (rf_model[3] !== 32'h11 || rf_model[4] !== 32'h22) begin
      fails++;
      $display("FAIL passthrough_rf: r3=%h r4=%h, required 11 22", rf_model[3], rf_model[4]);
    end
    check_drained("passthrough");
  endtask

  task automatic test_ll_fill();
    alloc_valid = 1; alloc_addr = 5'd5;
    tick(); idle();
    tests_run++;
    if (busy_mask[5] !== 1'b1) begin
      fails++;
      $display("FAIL fill_alloc_busy: busy[5]=%b, required 1", busy_mask[5]);
    end
    ll_valid = 1; ll_addr = 5'd5; ll_data = 32'hAA;
    pipe0(5'd1, 32'h01); pipe1(5'd2, 32'h02);
    tick(); idle();
    pipe0(5'd1, 32'h03); pipe1(5'd2, 32'h04);
    #1;
    tests_run++;
    if (busy_mask[5] !== 1'b1) begin
      fails++;
      $display("FAIL fill_held_busy: busy[5]=%b, required 1", busy_mask[5]);
    end
    tick(); idle();
    pipe0(5'd1, 32'h05);
    exp_q.push_back({2'd2, 5'd5, 32'hAA});
    #1;
    tests_run++;
    if (rf_we2 !== 1 || rf_waddr2 !== 5'd5 || rf_wdata2 !== 32'hAA) begin
      fails++;
      $display("FAIL fill_drain_port2: we2=%b a2=%0d d2=%h, required 1 5 aa", rf_we2, rf_waddr2, rf_wdata2);
    end
    tick(); idle();
    tests_run++;
    if (busy_mask[5] !== 1'b0 || rf_model[5] !== 32'hAA) begin
      fails++;
      $display("FAIL fill_retire: busy[5]=%b r5=%h, required 0 aa", busy_mask[5], rf_model[5]);
    end
    check_drained("ll_fill");
  endtask

  task automatic test_full();
    logic [4:0] regs [3];
    regs[0] = 5'd6; regs[1] = 5'd7; regs[2] = 5'd11;
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1; alloc_addr = regs[i];
      tick(); idle();
    end
    ll_valid = 1; ll_addr = 5'd6; ll_data = 32'h66;
    pipe0(5'd1, 32'h10); pipe1(5'd2, 32'h20);
    tick(); idle();
    ll_valid = 1; ll_addr = 5'd7; ll_data = 32'h77;
    pipe0(5'd1, 32'h11); pipe1(5'd2, 32'h21);
    #1;
    tests_run++;
    if (ll_ready !== 1'b1) begin
      fails++;
      $display("FAIL full_second_ready: ready=%b, required 1", ll_ready);
    end
    tick(); idle();
    ll_valid = 1; ll_addr = 5'd11; ll_data = 32'hBB;
    pipe0(5'd1, 32'h12); pipe1(5'd2, 32'h22);
    #1;
    tests_run++;
    if (ll_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_third_ready: ready=%b, required 0", ll_ready);
    end
    tick(); idle();
    ll_valid = 1; ll_addr = 5'd11; ll_data = 32'hBB;
    exp_q.push_back({2'd1, 5'd6, 32'h66});
    pipe1(5'd2, 32'h23);
    #1;
    tests_run++;
    if (ll_ready !== 1'b0 || rf_we1 !== 1'b1 || rf_waddr1 !== 5'd6) begin
      fails++;
      $display("FAIL full_drain_no_bypass: ready=%b we1=%b a1=%0d, required 0 1 6",
               ll_ready, rf_we1, rf_waddr1);
    end
    tick(); idle();
    ll_valid = 1; ll_addr = 5'd11; ll_data = 32'hBB;
    exp_q.push_back({2'd1, 5'd7, 32'h77});
    #1;
    tests_run++;
    if (ll_ready !== 1'b1) begin
      fails++;
      $display("FAIL full_ready_after_pop: ready=%b, required 1", ll_ready);
    end
    tick(); idle();
    exp_q.push_back({2'd1, 5'd11, 32'hBB});
    tick(); idle();
    tests_run++;
    if (busy_mask !== '0 || rf_model[11] !== 32'hBB) begin
      fails++;
      $display("FAIL full_retire: busy=%h r11=%h, required 0 bb", busy_mask, rf_model[11]);
    end
    check_drained("full");
  endtask

  task automatic test_stale();
    alloc_valid = 1; alloc_addr = 5'd8;
    tick(); idle();
    pipe0(5'd8, 32'h1);
    tick(); idle();
    ll_valid = 1; ll_addr = 5'd8; ll_data = 32'h2;
    tick(); idle();
    #1;
    tests_run++;
    if (rf_we1 !== 1'b0 || rf_we2 !== 1'b0) begin
      fails++;
      $display("FAIL stale_suppress: we1=%b we2=%b, required 0 0", rf_we1, rf_we2);
    end
    tick();
    tests_run++;
    if (busy_mask[8] !== 1'b0 || rf_model[8] !== 32'h1) begin
      fails++;
      $display("FAIL stale_retire: busy[8]=%b r8=%h, required 0 1", busy_mask[8], rf_model[8]);
    end
    check_drained("stale");
  endtask

  task automatic test_same_cycle();
    alloc_valid = 1; alloc_addr = 5'd9;
    pipe1(5'd9, 32'h99);
    tick(); idle();
    tests_run++;
    if (busy_mask[9] !== 1'b1) begin
      fails++;
      $display("FAIL same_alloc_busy: busy[9]=%b, required 1", busy_mask[9]);
    end
    ll_valid = 1; ll_addr = 5'd9; ll_data = 32'h9A;
    tick(); idle();
    exp_q.push_back({2'd1, 5'd9, 32'h9A});
    tick();
    tests_run++;
    if (rf_model[9] !== 32'h9A || busy_mask[9] !== 1'b0) begin
      fails++;
      $display("FAIL same_alloc_not_stale: r9=%h busy[9]=%b, required 9a 0", rf_model[9], busy_mask[9]);
    end
    alloc_valid = 1; alloc_addr = 5'd10;
    tick(); idle();
    ll_valid = 1; ll_addr = 5'd10; ll_data = 32'hA0;
    pipe0(5'd1, 32'h31); pipe1(5'd2, 32'h32);
    tick(); idle();
    pipe0(5'd10, 32'h10);
    #1;
    tests_run++;
    if (rf_we2 !== 1'b0) begin
      fails++;
      $display("FAIL same_head_suppress: we2=%b, required 0", rf_we2);
    end
    tick(); idle();
    tests_run++;
    if (busy_mask[10] !== 1'b0 || rf_model[10] !== 32'h10) begin
      fails++;
      $display("FAIL same_head_retire: busy[10]=%b r10=%h, required 0 10", busy_mask[10], rf_model[10]);
    end
    check_drained("same_cycle");
  endtask

  task automatic test_reset_mid();
    alloc_valid = 1; alloc_addr = 5'd12;
    tick(); idle();
    alloc_valid = 1; alloc_addr = 5'd13;
    tick(); idle();
    ll_valid = 1; ll_addr = 5'd12; ll_data = 32'hC;
    pipe0(5'd1, 32'h41); pipe1(5'd2, 32'h42);
    tick(); idle();
    ll_valid = 1; ll_addr = 5'd13; ll_data = 32'hD;
    pipe0(5'd1, 32'h43); pipe1(5'd2, 32'h44);
    tick(); idle();
    tests_run++;
    if (ll_ready !== 1'b0 || busy_mask[13:12] !== 2'b11) begin
      fails++;
      $display("FAIL midreset_full: ready=%b busy[13:12]=%b, required 0 11", ll_ready, busy_mask[13:12]);
    end
    resetn = 0;
    #1;
    tests_run++;
    if (rf_we1 !== 1'b0 || rf_we2 !== 1'b0 || ll_ready !== 1'b0) begin
      fails++;
      $display("FAIL midreset_gating: we1=%b we2=%b ready=%b, required 0 0 0", rf_we1, rf_we2, ll_ready);
    end
    tick();
    tests_run++;
    if (busy_mask !== '0 || ll_ready !== 1'b0) begin
      fails++;
      $display("FAIL midreset_clear: busy=%h ready=%b, required 0 0", busy_mask, ll_ready);
    end
    resetn = 1;
    tick();
    tests_run++;
    if (ll_ready !== 1'b1 || busy_mask !== '0) begin
      fails++;
      $display("FAIL midreset_after: ready=%b busy=%h, required 1 0", ll_ready, busy_mask);
    end
    // Buffered entries must be gone: idle cycles produce no writes.
    tick(); tick(); tick();
    check_drained("reset_mid");
  endtask

  initial begin
    for (int i = 0; i < NumRegs; i++) rf_model[i] = '0;
    idle();
    resetn = 0;
    test_reset();
    test_passthrough();
    test_ll_fill();
    test_full();
    test_stale();
    test_same_cycle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
